// File: rtl/execute_stage.sv
`default_nettype none
// =============================================================================
// execute_stage : MIPS EX stage - operand forwarding, ALU, iterative MUL/DIV
//                 unit owning HI/LO, and the EX/MEM pipeline register.
// Revision      : 1.0
// =============================================================================
module execute_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_valid,
  input  logic        reg_wr_en,
  input  logic        mem_wr_en,
  input  logic        mem_to_reg_wr,
  input  logic [4:0]  reg_wr_addr,
  input  logic [4:0]  alu_op,
  input  logic        alu_src,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  logic [31:0] ex_mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  output logic        ex_mem_reg_wr_en,
  output logic        ex_mem_mem_wr_en,
  output logic        ex_mem_mem_to_reg_wr,
  output logic [4:0]  ex_mem_reg_wr_addr,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_mem_wr_data,
  output logic        ex_stall
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_MFHI  = 5'd16;
  localparam logic [4:0] OP_MFLO  = 5'd17;
  localparam logic [4:0] OP_MTHI  = 5'd18;
  localparam logic [4:0] OP_MTLO  = 5'd19;

  localparam logic [5:0] LAST_ITER = 6'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] w_fa;
  logic [31:0] w_fb;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_result;
  logic        w_hilo;
  logic        w_md_op;
  logic        w_signed_op;
  logic        w_advance;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [63:0] w_prod;

  // Forwarding muxes: code 11 falls back to the register file value.
  always_comb begin
    case (fwd_a_sel)
      2'b01:   w_fa = ex_mem_fwd_data;
      2'b10:   w_fa = wb_fwd_data;
      default: w_fa = rs_data;
    endcase
    case (fwd_b_sel)
      2'b01:   w_fb = ex_mem_fwd_data;
      2'b10:   w_fb = wb_fwd_data;
      default: w_fb = rt_data;
    endcase
  end

  assign w_op_b      = alu_src ? imm : w_fb;
  assign w_hilo      = (alu_op >= OP_MULT) && (alu_op <= OP_MTLO);
  assign w_md_op     = (alu_op >= OP_MULT) && (alu_op <= OP_DIVU);
  assign w_signed_op = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign w_abs_a     = (w_signed_op && w_fa[31]) ? -w_fa : w_fa;
  assign w_abs_b     = (w_signed_op && w_fb[31]) ? -w_fb : w_fb;

  assign ex_stall  = id_ex_valid && w_hilo && (state_q != MD_IDLE);
  assign w_advance = id_ex_valid && !ex_stall;

  always_comb begin
    w_alu_result = '0;
    case (alu_op)
      OP_ADD:  w_alu_result = w_fa + w_op_b;
      OP_SUB:  w_alu_result = w_fa - w_op_b;
      OP_AND:  w_alu_result = w_fa & w_op_b;
      OP_OR:   w_alu_result = w_fa | w_op_b;
      OP_XOR:  w_alu_result = w_fa ^ w_op_b;
      OP_NOR:  w_alu_result = ~(w_fa | w_op_b);
      OP_SLT:  w_alu_result = {31'b0, $signed(w_fa) < $signed(w_op_b)};
      OP_SLTU: w_alu_result = {31'b0, w_fa < w_op_b};
      OP_SLL:  w_alu_result = w_fb << shamt;
      OP_SRL:  w_alu_result = w_fb >> shamt;
      OP_SRA:  w_alu_result = $signed(w_fb) >>> shamt;
      OP_LUI:  w_alu_result = {imm[15:0], 16'h0000};
      OP_MFHI: w_alu_result = hi_q;
      OP_MFLO: w_alu_result = lo_q;
      default: w_alu_result = '0;
    endcase
  end

  // EX/MEM register: bubbles clear only the control fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_mem_reg_wr_en     <= 1'b0;
      ex_mem_mem_wr_en     <= 1'b0;
      ex_mem_mem_to_reg_wr <= 1'b0;
      ex_mem_reg_wr_addr   <= '0;
      ex_mem_alu_result    <= '0;
      ex_mem_mem_wr_data   <= '0;
    end else if (w_advance) begin
      ex_mem_reg_wr_en     <= reg_wr_en;
      ex_mem_mem_wr_en     <= mem_wr_en;
      ex_mem_mem_to_reg_wr <= mem_to_reg_wr;
      ex_mem_reg_wr_addr   <= reg_wr_addr;
      ex_mem_alu_result    <= w_alu_result;
      ex_mem_mem_wr_data   <= w_fb;
    end else begin
      ex_mem_reg_wr_en     <= 1'b0;
      ex_mem_mem_wr_en     <= 1'b0;
      ex_mem_mem_to_reg_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Unsigned core on magnitudes; acc_hi holds the partial product or the
  // running remainder, acc_lo the multiplier or the quotient being built.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    w_sum      = '0;
    w_shift    = '0;
    w_diff     = '0;
    w_prod     = '0;
    case (state_q)
      MD_IDLE: begin
        if (w_advance && w_md_op) begin
          state_d    = MD_RUN;
          cnt_d      = '0;
          acc_hi_d   = '0;
          acc_lo_d   = w_abs_a;
          opnd_d     = w_abs_b;
          is_div_d   = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
          neg_d      = w_signed_op && (w_fa[31] ^ w_fb[31]);
          rem_neg_d  = w_signed_op && w_fa[31];
          div_zero_d = (w_fb == 32'd0);
        end else if (w_advance && (alu_op == OP_MTHI)) begin
          hi_d = w_fa;
        end else if (w_advance && (alu_op == OP_MTLO)) begin
          lo_d = w_fa;
        end
      end
      MD_RUN: begin
        if (is_div_q) begin
          w_shift = {acc_hi_q, acc_lo_q[31]};
          w_diff  = w_shift - {1'b0, opnd_q};
          if (!w_diff[32]) begin
            acc_hi_d = w_diff[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b1};
          end else begin
            acc_hi_d = w_shift[31:0];
            acc_lo_d = {acc_lo_q[30:0], 1'b0};
          end
        end else begin
          w_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
          acc_hi_d = w_sum[32:1];
          acc_lo_d = {w_sum[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (is_div_q) begin
          lo_d = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? -acc_lo_q : acc_lo_q);
          hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
        end else begin
          w_prod = {acc_hi_q, acc_lo_q};
          if (neg_q) begin
            w_prod = -w_prod;
          end
          hi_d = w_prod[63:32];
          lo_d = w_prod[31:0];
        end
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline. It feeds the memory stage.
- Selects forwarded operands and computes the ALU result.
- Runs an iterative 32-cycle multiply/divide unit that owns the HI/LO registers.
- Registers the EX/MEM pipeline fields: reg_wr_en, mem_wr_en, mem_to_reg_wr, reg_wr_addr, alu_result and store data.
- Asserts ex_stall so the hazard unit freezes IF/ID/ID-EX while a HI/LO-class op waits on the busy unit.

Parameters:
- MD_CYCLES, 32: number of multiply/divide iteration cycles. Only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- id_ex_valid  in  1  instruction in EX is real, not a bubble
- reg_wr_en  in  1  GPR write enable
- mem_wr_en  in  1  store enable
- mem_to_reg_wr  in  1  load writeback select
- reg_wr_addr  in  5  destination GPR
- alu_op  in  5  operation code
- alu_src  in  1  1 selects imm as operand B
- rs_data  in  32  register-file rs value
- rt_data  in  32  register-file rt value
- imm  in  32  sign/zero-extended immediate
- shamt  in  5  shift amount
- fwd_a_sel  in  2  operand A source: 00 rs_data, 01 ex_mem_fwd_data, 10 wb_fwd_data, 11 rs_data
- fwd_b_sel  in  2  operand B source, same coding with rt_data
- ex_mem_fwd_data  in  32  forward from EX/MEM
- wb_fwd_data  in  32  forward from WB
- ex_mem_reg_wr_en  out  1  registered
- ex_mem_mem_wr_en  out  1  registered
- ex_mem_mem_to_reg_wr  out  1  registered
- ex_mem_reg_wr_addr  out  5  registered
- ex_mem_alu_result  out  32  registered; also the memory address
- ex_mem_mem_wr_data  out  32  registered forwarded B (store data)
- ex_stall  out  1  combinational stall request

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. Port names are clk and reset; reset=0 at a rising clk edge resets the block.
- Reset values:
  - All ex_mem_* outputs = 0.
  - HI = LO = 0.
  - FSM = IDLE, ex_stall = 0.
  - Reset mid-operation aborts the multiply/divide; HI/LO are not updated.
- Operand selection:
  - fa = mux(fwd_a_sel); fb = mux(fwd_b_sel).
  - opB = alu_src ? imm : fb.
  - Store data = fb.
- alu_op codes:
  - 0 ADD: fa+opB, wraps, no trap
  - 1 SUB
  - 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed), 7 SLTU: result 1 or 0
  - 8 SLL, 9 SRL, 10 SRA: fb shifted by shamt
  - 11 LUI: {imm[15:0], 16'h0}
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU
  - 16 MFHI, 17 MFLO
  - 18 MTHI (HI<=fa), 19 MTLO (LO<=fa)
  - 20–31 result 0
- Pipeline register: latency 1. Each non-stalled edge captures the control inputs, reg_wr_addr, the result and store data.
- Bubble: when id_ex_valid=0 or ex_stall=1, the three control outputs load 0 and the data outputs hold their previous values.
- MULT/DIV/MULTU/DIVU results go only to HI/LO. Decode drives reg_wr_en=0 for them; alu_result = 0.
- hilo-class = ops 12–19.
- ex_stall = id_ex_valid && hilo-class && FSM!=IDLE. Non-hilo ops proceed normally while the unit is busy.
- FSM:
  - IDLE: on a valid, unstalled op 12–15, latch |fa|, |fb| (or raw for U variants), the result signs and the op; clear the counter; go to RUN.
  - MTHI/MTLO write HI/LO at the edge, only in IDLE.
  - RUN: one shift-add (MULT) or restoring-subtract (DIV) iteration per cycle. After MD_CYCLES iterations go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE. Busy is therefore 33 cycles from the issue edge.
- Signed results:
  - Product is negated if the operand signs differ.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
- Divide by zero (either signedness): LO=0xFFFFFFFF, HI=dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- A held MFHI/MFLO deasserts ex_stall in the cycle after FIX and reads the updated HI/LO.

Test Plan:
- Reset low for 2 cycles, with all inputs nonzero -> every ex_mem_* output = 0, ex_stall=0, MFHI then returns 0.
- ADDI forward: rs_data=5, fwd_a_sel=01, ex_mem_fwd_data=0x10, imm=3, alu_src=1, reg_wr_en=1 -> next edge ex_mem_alu_result=0x13, ex_mem_reg_wr_en=1. SRA: fb=0x80000000, shamt=4 -> 0xF8000000.
- MULT fa=0xFFFFFFFE, fb=3, followed by MFHI -> ex_stall high for exactly 33 cycles, then ex_mem_alu_result=0xFFFFFFFF. MFLO then returns 0xFFFFFFFA.
- Divides:
  - DIVU 100/7 -> LO=14, HI=2.
  - DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 5/0 -> LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT then ADD (valid) next cycle -> ADD not stalled, result registered at the next edge. MULT then DIV -> DIV stalled until IDLE, with bubbles (controls 0) in EX/MEM meanwhile.
- Reset low on busy cycle 10 of a MULT -> FSM IDLE, HI=LO=0, ex_stall=0 on the following cycle, no late HI/LO write.
